// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE / RD / WR)
//   gnt_id_t    : which requester owns the memory port
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2,
    GNT_LD   = 2'd3
  } gnt_id_t;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// arb_prio: fixed-priority grant for the memory port.
//   ld_req, d_req, if_req : requests
//   starve                : fetch has waited STARVE_MAX data grants
//   gnt                   : winning requester (GNT_NONE if idle)
// Loader always wins; starvation only reorders fetch over data.
import mem_port_arbiter_pkg::*;

module arb_prio (
  input  logic    ld_req,
  input  logic    d_req,
  input  logic    if_req,
  input  logic    starve,
  output gnt_id_t gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (ld_req)                gnt = GNT_LD;
    else if (if_req && starve) gnt = GNT_IF;
    else if (d_req)            gnt = GNT_D;
    else if (if_req)           gnt = GNT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction
// fetch (if_*), data access (d_*) and a program loader (ld_*).
//   clock, resetn       : clock, async active-low reset
//   if_req/addr/rdata/ready, d_req/we/addr/wdata/rdata/ready,
//   ld_req/addr/wdata/ready : requester ports (ready = one-cycle done pulse)
//   mem_en/we/addr/wdata/rdata : memory port, word addressed, rdata next cycle
//   cpu_stall           : pipeline hold while a CPU request is outstanding
// One access in flight: issue in IDLE, complete (ready) the next cycle.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_nx;
  gnt_id_t           gnt, gnt_q;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve;
  logic              issue, issue_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]       gnt_wdata;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              d_rd_done;
  logic              unused_addr_lsb;

  assign starve = (starve_cnt == CNT_W'(STARVE_MAX));

  arb_prio u_prio (
    .ld_req (ld_req),
    .d_req  (d_req),
    .if_req (if_req),
    .starve (starve),
    .gnt    (gnt)
  );

  // Grants are only taken in IDLE; RD/WR are the completion cycle.
  assign issue = (state == IDLE) && (gnt != GNT_NONE);

  always_comb begin
    gnt_addr  = if_addr;
    gnt_wdata = '0;
    issue_we  = 1'b0;
    case (gnt)
      GNT_LD: begin
        gnt_addr  = ld_addr;
        gnt_wdata = ld_wdata;
        issue_we  = 1'b1;
      end
      GNT_D: begin
        gnt_addr  = d_addr;
        gnt_wdata = d_wdata;
        issue_we  = d_we;
      end
      default: ;
    endcase
  end

  // Byte offset is dropped; misalignment is silently ignored.
  assign unused_addr_lsb = ^gnt_addr[1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = issue_we ? WR : RD;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en    = issue;
  assign mem_we    = issue && issue_we;
  assign mem_addr  = issue ? gnt_addr[ADDR_W-1:2] : addr_q;
  assign mem_wdata = issue ? gnt_wdata : '0;

  assign if_ready  = (state == RD) && (gnt_q == GNT_IF);
  assign d_ready   = (state != IDLE) && (gnt_q == GNT_D);
  assign ld_ready  = (state == WR) && (gnt_q == GNT_LD);
  assign d_rd_done = (state == RD) && (gnt_q == GNT_D);

  // Read data is forwarded in the ready cycle and held afterwards.
  assign if_rdata  = if_ready  ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rd_done ? mem_rdata : d_rdata_q;

  assign cpu_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      gnt_q      <= GNT_NONE;
      addr_q     <= '0;
      starve_cnt <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (issue) begin
        gnt_q  <= gnt;
        addr_q <= gnt_addr[ADDR_W-1:2];
      end
      if (if_ready)  if_rdata_q <= mem_rdata;
      if (d_rd_done) d_rdata_q  <= mem_rdata;
      // Only data grants taken while fetch is waiting count toward starvation.
      if (!if_req || (issue && gnt == GNT_IF))
        starve_cnt <= '0;
      else if (issue && gnt == GNT_D && !starve)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// issues; a negedge monitor matches each issue and its ready/rdata pulse.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rdy;    // {ld, d, if}
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        if_req, d_req, d_we, ld_req;
  logic [31:0] if_addr, d_addr, d_wdata, ld_addr, ld_wdata;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_ready, d_ready, ld_ready, mem_en, mem_we, cpu_stall;
  logic [29:0] mem_addr;

  logic [31:0] mem_model [0:63];
  exp_t        exp_q [$];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(3)) dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  // Synchronous memory: read data valid the cycle after issue.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[5:0]] = mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[5:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [29:0] a, input logic [31:0] wd,
                      input logic [2:0] rdy, input logic [31:0] rd);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.rdy = rdy; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: issue in one cycle, matching ready exactly in the next.
  logic pend = 1'b0;
  exp_t pend_e;
  always @(negedge clock) begin
    if (!resetn) begin
      pend = 1'b0;
      if (if_ready | d_ready | ld_ready)
        chk("ready_in_reset", {29'd0, ld_ready, d_ready, if_ready}, 32'd0);
    end else begin
      if (pend) begin
        chk("ready", {29'd0, ld_ready, d_ready, if_ready}, {29'd0, pend_e.rdy});
        if (!pend_e.we)
          chk("rdata", pend_e.rdy[0] ? if_rdata : d_rdata, pend_e.rdata);
        chk("no_b2b_issue", {31'd0, mem_en}, 32'd0);
        pend = 1'b0;
      end else begin
        if (if_ready | d_ready | ld_ready)
          chk("spurious_ready", {29'd0, ld_ready, d_ready, if_ready}, 32'd0);
        if (mem_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", {2'd0, mem_addr}, 32'hFFFF_FFFF);
          end else begin
            pend_e = exp_q.pop_front();
            chk("issue_we", {31'd0, mem_we}, {31'd0, pend_e.we});
            chk("issue_addr", {2'd0, mem_addr}, {2'd0, pend_e.addr});
            if (pend_e.we) chk("issue_wdata", mem_wdata, pend_e.wdata);
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'hA000_0000 + i;
    mem_model[4] = 32'h8C01_0004;
    resetn = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; ld_req = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; ld_addr = 0; ld_wdata = 0;
    tick(2);
    chk("rst_ctrl", {26'd0, mem_en, mem_we, if_ready, d_ready, ld_ready, cpu_stall}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    resetn = 1'b1;

    // Single fetch from word 4.
    push(0, 30'd4, 0, 3'b001, 32'h8C01_0004);
    if_req = 1; if_addr = 32'h10;
    tick(1); if_req = 0;
    tick(2);

    // Data write beats a same-cycle fetch; fetch follows.
    push(1, 30'd8, 32'hDEAD_BEEF, 3'b010, 0);
    push(0, 30'd4, 0, 3'b001, 32'h8C01_0004);
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h10;
    tick(1); d_req = 0; d_we = 0;
    tick(2); if_req = 0;
    tick(2);
    chk("word8", mem_model[8], 32'hDEAD_BEEF);

    // Starvation: d,d,d,if,d.
    push(0, 30'd0, 0, 3'b010, 32'hA000_0000);
    push(0, 30'd1, 0, 3'b010, 32'hA000_0001);
    push(0, 30'd2, 0, 3'b010, 32'hA000_0002);
    push(0, 30'd4, 0, 3'b001, 32'h8C01_0004);
    push(0, 30'd3, 0, 3'b010, 32'hA000_0003);
    d_req = 1; d_addr = 32'h0; if_req = 1; if_addr = 32'h10;
    tick(1); d_addr = 32'h4;
    tick(2); d_addr = 32'h8;
    tick(2); d_addr = 32'hC;
    tick(2); if_req = 0;
    tick(2); d_req = 0;
    tick(4);
    chk("d_rdata_hold", d_rdata, 32'hA000_0003);
    chk("if_rdata_hold", if_rdata, 32'h8C01_0004);

    // Loader burst locks out a waiting fetch.
    for (int k = 0; k < 8; k++) push(1, 30'(k), 32'(k + 1), 3'b100, 0);
    push(0, 30'd5, 0, 3'b001, 32'h0000_0006);
    ld_req = 1; if_req = 1; if_addr = 32'h14;
    for (int k = 0; k < 8; k++) begin
      ld_addr = 32'(4 * k); ld_wdata = 32'(k + 1);
      repeat (2) begin
        #2; chk("stall_during_ld", {31'd0, cpu_stall}, 32'd1);
        @(posedge clock); #1;
      end
    end
    ld_req = 0;
    tick(1); if_req = 0;
    tick(2);
    for (int k = 0; k < 8; k++) chk("ld_word", mem_model[k], 32'(k + 1));

    // Reset while a fetch is in RD: abandoned, then normal service.
    push(0, 30'd4, 0, 3'b001, 32'h0);
    if_req = 1; if_addr = 32'h10;
    tick(1); if_req = 0; resetn = 0;
    #2;
    chk("rst_rd_ctrl", {26'd0, mem_en, mem_we, if_ready, d_ready, ld_ready, cpu_stall}, 32'd0);
    chk("rst_rd_if_rdata", if_rdata, 32'd0);
    chk("rst_rd_d_rdata", d_rdata, 32'd0);
    tick(2); resetn = 1;
    push(0, 30'd4, 0, 3'b010, 32'h0000_0005);
    d_req = 1; d_addr = 32'h10;
    tick(1); d_req = 0;
    tick(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of all ports.
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning the maximum consecutive data grants while fetch waits.
REQ-003 SHALL have ports: clock  in  1  single clock, rising edge; resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch address; if_rdata  out  32  fetched word; if_ready  out  1  fetch done pulse.
REQ-005 SHALL have ports: d_req  in  1  data request; d_we  in  1  data write; d_addr  in  ADDR_W; d_wdata  in  32; d_rdata  out  32; d_ready  out  1  data done pulse.
REQ-006 SHALL have ports: ld_req  in  1  loader write request; ld_addr  in  ADDR_W; ld_wdata  in  32; ld_ready  out  1  loader done pulse.
REQ-007 SHALL have ports: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W-2  word address; mem_wdata  out  32; mem_rdata  in  32, valid the cycle after a read issue.
REQ-008 SHALL have port cpu_stall  out  1  hold for PC, IF/ID and ID/EX registers.

Function
REQ-009 SHALL use FSM states IDLE, RD (read issued, awaiting mem_rdata), WR (write issued).
REQ-010 SHALL, in IDLE, grant at most one requester per cycle: ld > d > if, except the starvation rule (REQ-014).
REQ-011 SHALL, on a read grant, drive mem_en=1, mem_we=0, mem_addr=addr[ADDR_W-1:2] that cycle, go to RD, and register the grantee ID and address.
REQ-012 SHALL, in RD, capture mem_rdata into if_rdata or d_rdata, pulse the matching ready for exactly one cycle, and return to IDLE: read latency = 2 cycles from grant.
REQ-013 SHALL, on a write grant (d_we=1 or loader), drive mem_en=1, mem_we=1, mem_wdata and go to WR; in WR it SHALL pulse the matching ready and return to IDLE: write latency = 2 cycles.
REQ-014 SHALL count consecutive d grants while if_req is high; when the count equals STARVE_MAX, the next IDLE grant SHALL go to fetch even if d_req is high; count clears on any fetch grant or when if_req is low.
REQ-015 SHALL not preempt loader: while ld_req is high, no CPU request is granted.
REQ-016 SHALL hold if_rdata and d_rdata stable between their ready pulses.
REQ-017 SHALL drive cpu_stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinationally.
REQ-018 SHALL drive mem_en=0 in IDLE with no request, and in RD and WR (no back-to-back issue).
REQ-019 SHALL treat a requester deasserting its req while granted as a don't-care: the access completes and ready still pulses.
REQ-020 SHALL ignore address bits [1:0]; misaligned addresses are not flagged.

Reset
REQ-021 SHALL, on resetn low, asynchronously enter IDLE, clear the starvation counter, and drive if_ready, d_ready, ld_ready, mem_en, mem_we, cpu_stall-internal state to 0 and if_rdata, d_rdata to 0.
REQ-022 SHALL abandon any in-flight access on reset; no ready pulse follows reset release for it.
REQ-023 SHALL accept requests in the first rising edge after resetn goes high.

Structure
REQ-024 SHALL place the state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2) and grantee IDs (GNT_IF, GNT_D, GNT_LD) in a shared package/include used by the cpu top level.
REQ-025 SHALL be one module plus one sub-module, arb_prio, computing the grant from ld_req, d_req, if_req and the starve flag.

Verification
REQ-026 Bench SHALL check: if_req, if_addr=0x10, mem holds 0x8C010004 at word 4 -> mem_addr=4 at cycle 0, if_ready and if_rdata=0x8C010004 at cycle 1.
REQ-027 Bench SHALL check: if_req and d_req (d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF) same cycle -> data write first, word 8 = 0xDEADBEEF, d_ready cycle 1, fetch granted cycle 2, if_ready cycle 3.
REQ-028 Bench SHALL check: d_req held high with 4 reads, if_req high, STARVE_MAX=3 -> grant order d,d,d,if,d.
REQ-029 Bench SHALL check: ld_req writes 0x00000001..0x00000008 to words 0..7 with if_req high -> no if grant until ld_req drops; cpu_stall=1 throughout.
REQ-030 Bench SHALL check: resetn pulsed low in RD state -> no ready pulse, mem_en=0, outputs 0, next request served normally.
